// File: rtl/interleaver_pkg.sv
// Shared constants and sync FSM state type for the interleaver input commutator.
package interleaver_pkg;

  localparam int NUM_BRANCH = 12;
  localparam int PKT_LEN    = 204;
  localparam logic [7:0] SYNC_BYTE = 8'h47;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } sync_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/interleaver_commutator_sync_detector.sv
// Packet sync acquisition FSM: counts correctly spaced sync hits to lock and
// consecutive missing syncs to drop lock; tells the top which bytes to forward.
module sync_detector
  import interleaver_pkg::*;
#(
  parameter int LOCK_CNT = 3,
  parameter int LOSS_CNT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_accept,
  input  logic        i_match,
  input  logic        i_pos0,
  output sync_state_t o_state,
  output logic        o_locked,
  output logic        o_fwd_en
);

  localparam int CNT_W = $clog2(max_int(LOCK_CNT, LOSS_CNT) + 1);
  localparam logic [CNT_W-1:0] LOCK_C = CNT_W'(LOCK_CNT);
  localparam logic [CNT_W-1:0] LOSS_C = CNT_W'(LOSS_CNT);

  sync_state_t      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_hit_cnt, w_hit_nxt;
  logic [CNT_W-1:0] r_miss_cnt, w_miss_nxt;
  logic [CNT_W-1:0] w_hit_inc, w_miss_inc;

  assign w_hit_inc  = r_hit_cnt + 1'b1;
  assign w_miss_inc = r_miss_cnt + 1'b1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= SEARCH;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_hit_cnt  <= w_hit_nxt;
      r_miss_cnt <= w_miss_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hit_nxt   = r_hit_cnt;
    w_miss_nxt  = r_miss_cnt;
    o_fwd_en    = 1'b0;
    if (i_accept) begin
      case (r_state)
        SEARCH: begin
          if (i_match) begin
            w_state_nxt = VERIFY;
            w_hit_nxt   = CNT_W'(1);
            w_miss_nxt  = '0;
          end
        end
        VERIFY: begin
          if (i_pos0) begin
            if (i_match) begin
              w_hit_nxt = w_hit_inc;
              // The locking sync byte itself is the first forwarded byte.
              if (w_hit_inc == LOCK_C) begin
                w_state_nxt = LOCKED;
                w_miss_nxt  = '0;
                o_fwd_en    = 1'b1;
              end
            end else begin
              w_state_nxt = SEARCH;
              w_hit_nxt   = '0;
            end
          end
        end
        LOCKED: begin
          o_fwd_en = 1'b1;
          if (i_pos0) begin
            if (i_match) begin
              w_miss_nxt = '0;
            end else if (w_miss_inc == LOSS_C) begin
              o_fwd_en    = 1'b0;
              w_state_nxt = SEARCH;
              w_hit_nxt   = '0;
              w_miss_nxt  = '0;
            end else begin
              w_miss_nxt = w_miss_inc;
            end
          end
        end
        default: w_state_nxt = SEARCH;
      endcase
    end
  end

  assign o_state  = r_state;
  assign o_locked = (r_state == LOCKED);

endmodule

// File: rtl/interleaver_commutator.sv
// Convolutional interleaver input commutator: sync-gated byte stream to a 1..N branch demux.
// Build option: define INTERLEAVER_SYNC_INV_EN to also accept the inverted sync byte.
module interleaver_commutator #(
  parameter int                DATA_W     = 8,
  parameter int                NUM_BRANCH = interleaver_pkg::NUM_BRANCH,
  parameter int                PKT_LEN    = interleaver_pkg::PKT_LEN,
  parameter logic [DATA_W-1:0] SYNC_BYTE  = DATA_W'(interleaver_pkg::SYNC_BYTE),
  parameter int                LOCK_CNT   = 3,
  parameter int                LOSS_CNT   = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [3:0]        sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              pkt_start
);

  import interleaver_pkg::*;

  localparam int              BC_W    = $clog2(PKT_LEN);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(PKT_LEN - 1);
  localparam logic [3:0]      NB      = 4'(NUM_BRANCH);

  logic [BC_W-1:0]   r_byte_cnt;
  logic [3:0]        r_branch;
  logic [DATA_W-1:0] r_data;
  logic [3:0]        r_sel;
  logic              r_out_valid;
  logic              r_pkt_start;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_match;
  logic              w_pos0;
  logic              w_fwd;
  logic              w_locked;
  logic [3:0]        w_branch_nxt;
  sync_state_t       w_state;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_pos0     = (r_byte_cnt == '0);

  always_comb begin
    w_match = (in_data == SYNC_BYTE);
`ifdef INTERLEAVER_SYNC_INV_EN
    w_match = w_match || (in_data == ~SYNC_BYTE);
`endif
  end

  sync_detector #(
    .LOCK_CNT (LOCK_CNT),
    .LOSS_CNT (LOSS_CNT)
  ) u_sync_detector (
    .clk      (clk),
    .rst      (rst),
    .i_accept (w_accept),
    .i_match  (w_match),
    .i_pos0   (w_pos0),
    .o_state  (w_state),
    .o_locked (w_locked),
    .o_fwd_en (w_fwd)
  );

  // Branch of the last forwarded byte is kept apart from sel, which idles at 0.
  assign w_branch_nxt = (w_pos0 || r_branch == NB) ? 4'd1 : r_branch + 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= '0;
      r_branch   <= '0;
    end else if (w_accept) begin
      if (w_state == SEARCH)
        r_byte_cnt <= w_match ? BC_W'(1) : '0;
      else
        r_byte_cnt <= (r_byte_cnt == BC_LAST) ? '0 : r_byte_cnt + 1'b1;
      if (w_fwd)
        r_branch <= w_branch_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_data      <= '0;
      r_sel       <= '0;
      r_pkt_start <= 1'b0;
    end else if (w_fwd) begin
      r_out_valid <= 1'b1;
      r_data      <= in_data;
      r_sel       <= w_branch_nxt;
      r_pkt_start <= w_pos0;
    end else if (w_in_ready) begin
      r_out_valid <= 1'b0;
      r_sel       <= '0;
      r_pkt_start <= 1'b0;
    end
  end

  assign in_ready  = w_in_ready;
  assign data_out  = r_data;
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign pkt_start = r_pkt_start;
  assign locked    = w_locked;

endmodule

// File: tb/tb_interleaver_commutator.sv
// Randomized bench for interleaver_commutator against a packet-level reference model.
module tb_interleaver_commutator;

  localparam int PKT = 204;
  localparam int NB  = 12;
`ifdef INTERLEAVER_SYNC_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] data_out;
  logic [3:0] sel;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       locked;
  logic       pkt_start;

  always #5 clk = ~clk;

  interleaver_commutator #(
    .DATA_W   (8),
    .LOCK_CNT (3),
    .LOSS_CNT (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .pkt_start (pkt_start)
  );

  typedef struct packed {
    logic       start;
    logic [3:0] br;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];
  int   mode;   // 0 searching, 1 verifying, 2 locked
  int   pos, hits, misses;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   hold_low = 0;
  bit   bp_mode  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_sync(input logic [7:0] b);
    return (b == 8'h47) || (INV && b == 8'hB8);
  endfunction

  task automatic model_reset();
    q.delete();
    mode = 0; pos = 0; hits = 0; misses = 0;
  endtask

  // Packet-level view: pos is the offset inside the packet, branch = pos mod NB + 1.
  task automatic model_byte(input logic [7:0] b);
    bit m = is_sync(b);
    case (mode)
      0: if (m) begin mode = 1; pos = 1; hits = 1; end
      1: begin
        if (pos == 0) begin
          if (m) begin
            hits++;
            if (hits == 3) begin
              mode = 2; misses = 0;
              q.push_back('{start: 1'b1, br: 4'd1, data: b});
            end
          end else mode = 0;
        end
        pos = (pos + 1) % PKT;
      end
      default: begin
        if (pos == 0) begin
          if (!m) misses++; else misses = 0;
          if (misses == 3) mode = 0;
          else q.push_back('{start: 1'b1, br: 4'd1, data: b});
        end else begin
          q.push_back('{start: 1'b0, br: 4'(pos % NB + 1), data: b});
        end
        pos = (pos + 1) % PKT;
      end
    endcase
  endtask

  task automatic do_cycle(input logic v, input logic [7:0] d, input logic r, output bit acc);
    bit rdy_exp;
    @(negedge clk);
    in_valid = v; in_data = d; out_ready = r;
    #1;
    rdy_exp = (q.size() == 0) || r;
    chk("in_ready", in_ready, rdy_exp);
    chk("out_valid", out_valid, q.size() != 0);
    chk("locked", locked, mode == 2);
    if (out_valid && q.size() != 0) begin
      chk("data_out", data_out, q[0].data);
      chk("sel", sel, q[0].br);
      chk("pkt_start", pkt_start, q[0].start);
      if (r) void'(q.pop_front());
    end else begin
      chk("sel_idle", sel, 0);
    end
    acc = v && rdy_exp;
    if (acc) model_byte(d);
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit acc = 1'b0;
    int tries = 0;
    logic v, r;
    while (!acc && tries < 100) begin
      v = bp_mode ? ($urandom_range(0, 4) != 0) : 1'b1;
      r = bp_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (hold_low > 0) begin v = 1'b1; r = 1'b0; hold_low--; end
      do_cycle(v, b, r, acc);
      tries++;
    end
    if (!acc) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_pkt(input logic [7:0] sync_b, input int hold_at, input int n_bytes);
    logic [7:0] b;
    send_byte(sync_b);
    for (int i = 1; i < n_bytes; i++) begin
      b = 8'($urandom);
      if (b == 8'h47 || b == 8'hB8) b = 8'h00;
      if (i == hold_at) hold_low = 5;
      send_byte(b);
    end
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_pkt_start"}, pkt_start, 0);
    chk({tag, "_data_out"}, data_out, 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit acc;
    model_reset();
    reset_check("reset");

    // Acquire lock on three clean packets, then backpressure mid-packet.
    for (int p = 0; p < 3; p++) send_pkt(8'h47, -1, PKT);
    chk("locked_after_3", locked, 1);
    send_pkt(8'h47, 100, PKT);
    bp_mode = 1'b1;
    for (int p = 0; p < 2; p++) send_pkt(8'h47, -1, PKT);

    // Three missing syncs drop lock.
    bp_mode = 1'b0;
    for (int p = 0; p < 3; p++) send_pkt(8'h00, -1, PKT);
    chk("unlocked_after_loss", locked, 0);

    // Missing sync during verification returns to search.
    send_pkt(8'h47, -1, PKT);
    send_pkt(8'h00, -1, PKT);
    send_pkt(8'h00, -1, PKT);
    chk("verify_fail_unlocked", locked, 0);
    bp_mode = 1'b1;
    for (int p = 0; p < 3; p++) send_pkt(8'h47, -1, PKT);
    chk("relocked", locked, 1);

    // Reset mid-packet, then inverted sync followed by normal syncs.
    bp_mode = 1'b0;
    send_pkt(8'h47, -1, 60);
    reset_check("midreset");
    send_pkt(8'hB8, -1, PKT);
    send_pkt(8'h47, -1, PKT);
    send_pkt(8'h47, -1, PKT);
    chk("inv_sync_lock", locked, INV);
    send_pkt(8'h47, -1, PKT);
    chk("lock_after_reset", locked, 1);

    for (int i = 0; i < 4; i++) do_cycle(1'b0, 8'h00, 1'b1, acc);
    chk("drain_empty", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
